// File: rtl/avl_bus_rr_arb.sv
// avl_bus_rr_arb: N-master to 1-slave Avalon-MM arbiter with round-robin grant and in-order read-ID tracking.
// Define AVL_BUS_RR_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module avl_bus_rr_arb #(
  parameter  int MASTER_NUM        = 2,
  parameter  int OUTSTANDING_DEPTH = 4,
  localparam int ID_W              = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1,
  localparam int PTR_W             = $clog2(OUTSTANDING_DEPTH),
  localparam int CNT_W             = $clog2(OUTSTANDING_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rest,
  input  logic [MASTER_NUM*32-1:0] m_address,
  input  logic [MASTER_NUM*4-1:0]  m_byte_en,
  input  logic [MASTER_NUM-1:0]    m_read,
  input  logic [MASTER_NUM-1:0]    m_write,
  input  logic [MASTER_NUM*32-1:0] m_write_data,
  output logic [MASTER_NUM-1:0]    m_wait_request,
  output logic [31:0]              m_read_data,
  output logic [MASTER_NUM-1:0]    m_read_data_valid,
  output logic [31:0]              s_address,
  output logic [3:0]               s_byte_en,
  output logic                     s_read,
  output logic                     s_write,
  output logic [31:0]              s_write_data,
  input  logic                     s_wait_request,
  input  logic [31:0]              s_read_data,
  input  logic                     s_read_data_valid,
  output logic [CNT_W-1:0]         outstanding,
  output logic                     err_unexp_rsp
);

  logic                  r_locked;
  logic [ID_W-1:0]       r_gnt_id;
  logic [ID_W-1:0]       r_last_id;
  logic [ID_W-1:0]       r_fifo [OUTSTANDING_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_err;

  logic [MASTER_NUM-1:0] w_req;
  logic                  w_gnt_vld;
  logic [ID_W-1:0]       w_gnt_id;
  logic [ID_W-1:0]       w_idx;
  logic                  w_is_read;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_block;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;

  assign w_req   = m_read | m_write;
  assign w_full  = (r_count == CNT_W'(OUTSTANDING_DEPTH));
  assign w_empty = (r_count == '0);

  // Iterate from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = r_gnt_id;
    w_idx     = '0;
    if (r_locked) begin
      w_gnt_vld = w_req[r_gnt_id];
    end else begin
`ifdef AVL_BUS_RR_ARB_FIXED_PRIO_EN
      for (int i = MASTER_NUM - 1; i >= 0; i--) begin
        w_idx = ID_W'(i);
        if (w_req[w_idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = w_idx;
        end
      end
`else
      for (int k = MASTER_NUM; k >= 1; k--) begin
        w_idx = ID_W'((int'(r_last_id) + k) % MASTER_NUM);
        if (w_req[w_idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = w_idx;
        end
      end
`endif
    end
  end

  assign w_is_read  = m_read[w_gnt_id];
  assign w_rd_block = w_gnt_vld & w_is_read & w_full;

  // Reset also masks the command strobes so nothing is accepted while rest is low.
  assign s_read       = rest & w_gnt_vld & w_is_read & ~w_full;
  assign s_write      = rest & w_gnt_vld & ~w_is_read;
  assign s_address    = w_gnt_vld ? m_address[int'(w_gnt_id)*32 +: 32] : 32'h0;
  assign s_byte_en    = w_gnt_vld ? m_byte_en[int'(w_gnt_id)*4 +: 4] : 4'h0;
  assign s_write_data = w_gnt_vld ? m_write_data[int'(w_gnt_id)*32 +: 32] : 32'h0;

  assign w_accept = (s_read | s_write) & ~s_wait_request;
  assign w_push   = w_accept & s_read;
  assign w_pop    = s_read_data_valid & ~w_empty;

  always_comb begin
    m_wait_request = '1;
    if (rest & w_gnt_vld & ~s_wait_request & ~w_rd_block)
      m_wait_request[w_gnt_id] = 1'b0;
  end

  always_comb begin
    m_read_data_valid = '0;
    if (w_pop)
      m_read_data_valid[r_fifo[r_rd_ptr]] = 1'b1;
  end

  assign m_read_data   = s_read_data;
  assign outstanding   = r_count;
  assign err_unexp_rsp = r_err;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_locked  <= 1'b0;
      r_gnt_id  <= '0;
      r_last_id <= ID_W'(MASTER_NUM - 1);
    end else if (w_accept) begin
      r_locked  <= 1'b0;
      r_last_id <= w_gnt_id;
    end else if (w_gnt_vld) begin
      r_locked  <= 1'b1;
      r_gnt_id  <= w_gnt_id;
    end else begin
      r_locked  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      for (int i = 0; i < OUTSTANDING_DEPTH; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_gnt_id;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push & ~w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop & ~w_push)
        r_count <= r_count - 1'b1;
      if (s_read_data_valid & w_empty)
        r_err <= 1'b1;
    end
  end

endmodule
